// File: rtl/fm_sb_mem_responder.sv
// -----------------------------------------------------------------------------
// fm_sb_mem_responder
//
// Responder side of one spy-buffer memory/meta port. Monitor words are captured
// into a circular buffer while freeze is low. The FM control block reads the
// buffer (and, while frozen, patches it) one AXI-width lane at a time through
// the sb_* strobe interface. A small 4-entry meta register file reports the
// capture state through the sm_* interface.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   fm_data/fm_vld  monitor word and its valid strobe
//   freeze          1 = capture stopped, memory writes allowed
//   sb_*            memory access: addr {word, lane}, enable, write enable, data
//   sm_*            meta access: addr[1:0], enable, write enable, data
//   spy_data        memory read data, valid with the spy_data_vld pulse
//   spy_meta_data   meta read data, one cycle after a meta read
//
// Meta map: 0 wr_ptr (RO), 1 {wr_reject, wrapped, freeze} (RO),
//           2 cap_cnt (any write clears cap_cnt/wrapped/wr_reject), 3 scratch.
// -----------------------------------------------------------------------------
module fm_sb_mem_responder #(
    parameter int MEM_AW = 10,
    parameter int MON_DW = 256,
    parameter int AXI_DW = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MON_DW-1:0] fm_data,
    input  logic              fm_vld,
    input  logic              freeze,
    input  logic [15:0]       sb_addr,
    input  logic              sb_enable,
    input  logic              sb_wr_enable,
    input  logic [AXI_DW-1:0] sb_wr_data,
    input  logic [15:0]       sm_addr,
    input  logic              sm_enable,
    input  logic              sm_wr_enable,
    input  logic [AXI_DW-1:0] sm_wr_data,
    output logic [AXI_DW-1:0] spy_data,
    output logic              spy_data_vld,
    output logic [AXI_DW-1:0] spy_meta_data
);

    localparam int SL    = MON_DW / AXI_DW;
    localparam int LW    = $clog2(SL);
    localparam int LWS   = (LW > 0) ? LW : 1;   // usable width even for a single lane
    localparam int SB_AW = MEM_AW + LW;
    localparam int DEPTH = 1 << MEM_AW;

    // Address decode and access qualification
    logic [MEM_AW-1:0] acc_word;
    logic [LWS-1:0]    acc_lane;
    logic              capture;
    logic              axi_wr;
    logic              axi_rej;
    logic              axi_rd;
    logic              meta_wr;
    logic              meta_rd;
    logic              meta_clr;
    logic [1:0]        meta_sel;

    assign acc_word = sb_addr[SB_AW-1:LW];
    assign acc_lane = (SL > 1) ? sb_addr[LWS-1:0] : '0;
    assign capture  = fm_vld & ~freeze;
    assign axi_wr   = sb_enable & sb_wr_enable & freeze;
    assign axi_rej  = sb_enable & sb_wr_enable & ~freeze;
    assign axi_rd   = sb_enable & ~sb_wr_enable;
    assign meta_wr  = sm_enable & sm_wr_enable;
    assign meta_rd  = sm_enable & ~sm_wr_enable;
    assign meta_sel = sm_addr[1:0];
    assign meta_clr = meta_wr & (meta_sel == 2'd2);

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, sb_addr[15:SB_AW], sm_addr[15:2]};

    // Capture state
    logic [MEM_AW-1:0] wr_ptr_reg;
    logic              wrapped_reg;
    logic              wr_reject_reg;
    logic [AXI_DW-1:0] cap_cnt_reg;
    logic [AXI_DW-1:0] scratch_reg;
    logic [AXI_DW-1:0] spy_meta_data_reg;
    logic [AXI_DW-1:0] meta_next;

    // -------------------------------------------------------------------------
    // Buffer: one RAM per lane. Capture (freeze=0) and AXI patch writes
    // (freeze=1) are mutually exclusive, so each lane needs a single write
    // port. Read and write sit in separate processes, so a read colliding with
    // a write to the same word returns the old contents.
    // -------------------------------------------------------------------------
    logic [SL*AXI_DW-1:0] rd_all;

    genvar gi;
    generate
        for (gi = 0; gi < SL; gi++) begin : g_lane
            logic [AXI_DW-1:0] mem [DEPTH];
            logic [AXI_DW-1:0] rd_q_reg;
            logic              lane_we;
            logic [MEM_AW-1:0] lane_wa;
            logic [AXI_DW-1:0] lane_wd;

            always_comb begin
                lane_we = capture | (axi_wr && (acc_lane == LWS'(gi)));
                lane_wa = capture ? wr_ptr_reg : acc_word;
                lane_wd = capture ? fm_data[gi*AXI_DW +: AXI_DW] : sb_wr_data;
            end

            always_ff @(posedge clk) begin
                if (!rst && lane_we) begin
                    mem[lane_wa] <= lane_wd;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q_reg <= '0;
                end else if (axi_rd) begin
                    rd_q_reg <= mem[acc_word];
                end
            end

            assign rd_all[gi*AXI_DW +: AXI_DW] = rd_q_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read pipeline. Stage 0 is the RAM output register; the lane select
    // travels alongside it. Further stages only load when a valid result
    // arrives, so spy_data holds the last returned value between pulses.
    // -------------------------------------------------------------------------
    logic [LWS-1:0]    lane_sel_reg;
    logic [RD_LAT-1:0] vld_pipe_reg;
    logic [AXI_DW-1:0] sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_sel_reg <= '0;
            vld_pipe_reg <= '0;
        end else begin
            if (axi_rd) begin
                lane_sel_reg <= acc_lane;
            end
            vld_pipe_reg[0] <= axi_rd;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_reg[k] <= vld_pipe_reg[k-1];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < SL; k++) begin
            if (lane_sel_reg == LWS'(k)) begin
                sel_data = rd_all[k*AXI_DW +: AXI_DW];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign spy_data = sel_data;
        end else begin : g_latn
            logic [AXI_DW-1:0] data_pipe_reg [RD_LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < RD_LAT-1; k++) begin
                        data_pipe_reg[k] <= '0;
                    end
                end else begin
                    if (vld_pipe_reg[0]) begin
                        data_pipe_reg[0] <= sel_data;
                    end
                    for (int k = 1; k < RD_LAT-1; k++) begin
                        if (vld_pipe_reg[k]) begin
                            data_pipe_reg[k] <= data_pipe_reg[k-1];
                        end
                    end
                end
            end

            assign spy_data = data_pipe_reg[RD_LAT-2];
        end
    endgenerate

    assign spy_data_vld = vld_pipe_reg[RD_LAT-1];

    // -------------------------------------------------------------------------
    // Meta registers. The read mux samples the registers before this cycle's
    // updates, so a same-cycle write/read returns the old value.
    // -------------------------------------------------------------------------
    always_comb begin
        meta_next = '0;
        case (meta_sel)
            2'd0:    meta_next = {{(AXI_DW-MEM_AW){1'b0}}, wr_ptr_reg};
            2'd1:    meta_next = {{(AXI_DW-3){1'b0}}, wr_reject_reg, wrapped_reg, freeze};
            2'd2:    meta_next = cap_cnt_reg;
            default: meta_next = scratch_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg        <= '0;
            wrapped_reg       <= 1'b0;
            wr_reject_reg     <= 1'b0;
            cap_cnt_reg       <= '0;
            scratch_reg       <= '0;
            spy_meta_data_reg <= '0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (wr_ptr_reg == {MEM_AW{1'b1}}) begin
                    wrapped_reg <= 1'b1;
                end
                if (cap_cnt_reg != {AXI_DW{1'b1}}) begin
                    cap_cnt_reg <= cap_cnt_reg + 1'b1;
                end
            end
            if (axi_rej) begin
                wr_reject_reg <= 1'b1;
            end
            // Clear comes last so it overrides a coincident capture or reject.
            if (meta_clr) begin
                cap_cnt_reg   <= '0;
                wrapped_reg   <= 1'b0;
                wr_reject_reg <= 1'b0;
            end
            if (meta_wr && (meta_sel == 2'd3)) begin
                scratch_reg <= sm_wr_data;
            end
            if (meta_rd) begin
                spy_meta_data_reg <= meta_next;
            end
        end
    end

    assign spy_meta_data = spy_meta_data_reg;

endmodule
